// File: rtl/src_req_arbiter_if.sv
// Bus bundle between the source-side requesters, the arbiter and the bridge slave port.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface src_req_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // requester side
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            i_req_rd0_wr1;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_REQ-1:0]            o_rsp_valid;
    logic [DATA_WIDTH-1:0]         o_rsp_data;
    // downstream bridge port
    logic                          o_valid;
    logic                          o_rd0_wr1;
    logic [ADDR_WIDTH-1:0]         o_addr;
    logic [DATA_WIDTH-1:0]         o_wr_data;
    logic                          i_ready;
    logic [DATA_WIDTH-1:0]         i_rd_data;
    logic                          i_rd_valid;
    // sleep handshake and status
    logic                          i_arb_sleep_req;
    logic                          o_arb_sleep_ack;
    logic                          o_rsp_orphan;

    modport slave (
        input  i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
        output o_req_ready, o_rsp_valid, o_rsp_data,
        output o_valid, o_rd0_wr1, o_addr, o_wr_data,
        input  i_ready, i_rd_data, i_rd_valid,
        input  i_arb_sleep_req,
        output o_arb_sleep_ack, o_rsp_orphan
    );

    modport master (
        output i_req_valid, i_req_rd0_wr1, i_req_addr, i_req_wr_data,
        input  o_req_ready, o_rsp_valid, o_rsp_data,
        input  o_valid, o_rd0_wr1, o_addr, o_wr_data,
        output i_ready, i_rd_data, i_rd_valid,
        output i_arb_sleep_req,
        input  o_arb_sleep_ack, o_rsp_orphan
    );
endinterface

// File: rtl/src_req_arbiter.sv
// Round-robin arbiter in front of the bridge source-side slave port.
// Outstanding reads are recorded in an in-order tag FIFO, so that returned read data
// is steered back to the requester that issued the read.
//
// state | meaning
// IDLE  | arbitrate: register the next eligible requester from the rr pointer
// GRANT | present the granted requester downstream until i_ready
// DRAIN | sleep requested: no new grants, wait for outstanding reads to return
// SLEEP | acknowledge sleep, no grants until the request drops
module src_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic               i_clk_src,
    input  logic               i_rst_src,
    src_req_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SLEEP = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_q, rr_d;

    logic [IDX_W-1:0]     tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                 orphan_q;

    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 in_grant;
    logic                 sel_rd0_wr1;
    logic                 handshake;
    logic                 push;
    logic                 pop;
    logic                 tags_full;
    logic [NUM_REQ-1:0]   ready_vec;

    assign in_grant    = (state_q == ST_GRANT);
    assign sel_rd0_wr1 = bus.i_req_rd0_wr1[grant_q];
    assign handshake   = in_grant && bus.i_ready;
    assign push        = handshake && !sel_rd0_wr1;
    assign pop         = bus.i_rd_valid && (count_q != '0);
    assign tags_full   = (count_q >= CNT_W'(TAG_DEPTH));

    // A read is only eligible while it can still get a tag. A write is always eligible.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = bus.i_req_valid[k] && (bus.i_req_rd0_wr1[k] || !tags_full);
        end
    end

    // Round-robin scan: the first eligible requester at or above the rr pointer, with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic. A sleep request never aborts a grant that has already been issued.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_arb_sleep_req) begin
                    state_d = ST_DRAIN;
                end else if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (handshake) begin
                    rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d = bus.i_arb_sleep_req ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!bus.i_arb_sleep_req) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (!bus.i_arb_sleep_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk_src or posedge i_rst_src) begin
        if (i_rst_src) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // In-order tag FIFO of read issuers. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge i_clk_src or posedge i_rst_src) begin
        if (i_rst_src) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= grant_q;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered response routing. The data register holds its value between responses.
    always_ff @(posedge i_clk_src or posedge i_rst_src) begin
        if (i_rst_src) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            orphan_q    <= 1'b0;
        end else begin
            rsp_valid_q <= pop ? (NUM_REQ'(1) << tag_mem_q[rd_ptr_q]) : '0;
            if (pop) begin
                rsp_data_q <= bus.i_rd_data;
            end
            orphan_q <= bus.i_rd_valid && (count_q == '0);
        end
    end

    // Only the granted requester sees the downstream ready.
    always_comb begin
        ready_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ready_vec[k] = handshake && (grant_q == IDX_W'(k));
        end
    end

    assign bus.o_req_ready     = ready_vec;
    assign bus.o_rsp_valid     = rsp_valid_q;
    assign bus.o_rsp_data      = rsp_data_q;
    assign bus.o_valid         = in_grant;
    assign bus.o_rd0_wr1       = in_grant && sel_rd0_wr1;
    assign bus.o_addr          = in_grant ? bus.i_req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.o_wr_data       = in_grant ? bus.i_req_wr_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.o_arb_sleep_ack = (state_q == ST_SLEEP);
    assign bus.o_rsp_orphan    = orphan_q;
endmodule

// File: tb/tb_src_req_arbiter.sv
// Directed bench for src_req_arbiter. Inputs are driven 1 ns after the rising edge.
// Outputs are checked 1 ns later, after combinational settling.
module tb_src_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    src_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    src_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .i_clk_src (clk),
        .i_rst_src (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int k, input logic [31:0] a);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
        chk({tag, ".ready"}, 32'(bus.o_req_ready), 32'(1) << k);
        chk({tag, ".addr"},  bus.o_addr, a);
    endtask

    task automatic set_req(input int k, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        bus.i_req_valid[k]          = v;
        bus.i_req_rd0_wr1[k]        = wr;
        bus.i_req_addr[k*AW +: AW]  = a;
        bus.i_req_wr_data[k*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_valid     = '0;
        bus.i_req_rd0_wr1   = '0;
        bus.i_req_addr      = '0;
        bus.i_req_wr_data   = '0;
        bus.i_ready         = 1'b0;
        bus.i_rd_data       = '0;
        bus.i_rd_valid      = 1'b0;
        bus.i_arb_sleep_req = 1'b0;

        // reset state
        tick(); settle();
        chk("rst.valid",     32'(bus.o_valid), 0);
        chk("rst.req_ready", 32'(bus.o_req_ready), 0);
        chk("rst.rsp_valid", 32'(bus.o_rsp_valid), 0);
        chk("rst.rsp_data",  bus.o_rsp_data, 0);
        chk("rst.ack",       32'(bus.o_arb_sleep_ack), 0);
        chk("rst.orphan",    32'(bus.o_rsp_orphan), 0);
        rst = 1'b0;

        // 1: three writes, grants 0,1,2 two cycles apart
        for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b1, 32'h100 + k, 32'hD0 + k);
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk_grant("t1.grant", k, 32'h100 + k);
            chk("t1.wdata", bus.o_wr_data, 32'hD0 + k);
            chk("t1.dir",   32'(bus.o_rd0_wr1), 1);
            tick(); bus.i_req_valid[k] = 1'b0; settle();
            chk("t1.gap_valid", 32'(bus.o_valid), 0);
            chk("t1.gap_ready", 32'(bus.o_req_ready), 0);
        end

        // reset to bring the rr pointer back to 0
        rst = 1'b1; tick(); rst = 1'b0;

        // 2: all four valid continuously -> 0,1,2,3,0
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b1, 32'h200 + k, 32'hE0 + k);
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk_grant("t2.grant", i % 4, 32'h200 + (i % 4));
            tick(); settle();
            chk("t2.gap_valid", 32'(bus.o_valid), 0);
        end
        bus.i_req_valid = '0;

        // 3: reads from req1 then req3, responses routed in order (rr now 1)
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0); settle();
        tick(); settle();
        chk_grant("t3.g1", 1, 32'h10);
        chk("t3.g1.dir", 32'(bus.o_rd0_wr1), 0);
        tick(); bus.i_req_valid[1] = 1'b0; set_req(3, 1'b1, 1'b0, 32'h20, 32'h0); settle();
        chk("t3.gap_valid", 32'(bus.o_valid), 0);
        tick(); settle();
        chk_grant("t3.g3", 3, 32'h20);
        tick(); bus.i_req_valid[3] = 1'b0; bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'hAA; settle();
        chk("t3.pre_rsp", 32'(bus.o_rsp_valid), 0);
        tick(); bus.i_rd_data = 32'hBB; settle();
        chk("t3.rsp1.valid", 32'(bus.o_rsp_valid), 32'b0010);
        chk("t3.rsp1.data",  bus.o_rsp_data, 32'hAA);
        tick(); bus.i_rd_valid = 1'b0; settle();
        chk("t3.rsp2.valid", 32'(bus.o_rsp_valid), 32'b1000);
        chk("t3.rsp2.data",  bus.o_rsp_data, 32'hBB);
        tick(); settle();
        chk("t3.idle.valid", 32'(bus.o_rsp_valid), 0);
        chk("t3.hold.data",  bus.o_rsp_data, 32'hBB);

        // 4: fill the tag FIFO with req2 reads, then req0 write passes, req2 blocked (rr now 0)
        set_req(2, 1'b1, 1'b0, 32'h30, 32'h0); settle();
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk_grant("t4.fill", 2, 32'h30);
            tick(); settle();
            chk("t4.fill_gap", 32'(bus.o_valid), 0);
        end
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h44); settle();
        tick(); settle();
        chk_grant("t4.wr0", 0, 32'h40);
        tick(); bus.i_req_valid[0] = 1'b0; settle();
        chk("t4.gap", 32'(bus.o_valid), 0);
        tick(); settle();
        chk("t4.blocked.valid", 32'(bus.o_valid), 0);
        chk("t4.blocked.ready", 32'(bus.o_req_ready), 0);
        bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'h11;
        tick(); bus.i_rd_valid = 1'b0; settle();
        chk("t4.pop.valid", 32'(bus.o_rsp_valid), 32'b0100);
        chk("t4.pop.data",  bus.o_rsp_data, 32'h11);
        chk("t4.pop.still_blocked", 32'(bus.o_valid), 0);
        tick(); settle();
        chk_grant("t4.unblocked", 2, 32'h30);
        tick(); bus.i_req_valid[2] = 1'b0; settle();
        bus.i_rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_rd_data = 32'h21 + i;
            tick(); settle();
            chk("t4.drain.valid", 32'(bus.o_rsp_valid), 32'b0100);
            chk("t4.drain.data",  bus.o_rsp_data, 32'h21 + i);
        end
        bus.i_rd_valid = 1'b0;
        tick(); settle();
        chk("t4.empty.valid",  32'(bus.o_rsp_valid), 0);
        chk("t4.empty.orphan", 32'(bus.o_rsp_orphan), 0);

        // 5: sleep with two reads outstanding and a stalled grant (rr now 3)
        set_req(1, 1'b1, 1'b0, 32'h50, 32'h0);
        set_req(3, 1'b1, 1'b0, 32'h70, 32'h0); settle();
        tick(); settle();
        chk_grant("t5.g3", 3, 32'h70);
        tick(); bus.i_req_valid[3] = 1'b0; settle();
        chk("t5.gap", 32'(bus.o_valid), 0);
        tick(); bus.i_ready = 1'b0; bus.i_arb_sleep_req = 1'b1; settle();
        chk("t5.stall.valid", 32'(bus.o_valid), 1);
        chk("t5.stall.ready", 32'(bus.o_req_ready), 0);
        chk("t5.stall.addr",  bus.o_addr, 32'h50);
        tick(); settle();
        chk("t5.held.valid", 32'(bus.o_valid), 1);
        chk("t5.held.ack",   32'(bus.o_arb_sleep_ack), 0);
        bus.i_ready = 1'b1; settle();
        chk("t5.accept.ready", 32'(bus.o_req_ready), 32'b0010);
        tick(); bus.i_req_valid[1] = 1'b0; settle();
        chk("t5.drain.valid", 32'(bus.o_valid), 0);
        chk("t5.drain.ack",   32'(bus.o_arb_sleep_ack), 0);
        tick(); bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'hC3; settle();
        chk("t5.drain2.ack", 32'(bus.o_arb_sleep_ack), 0);
        tick(); bus.i_rd_data = 32'hC1; settle();
        chk("t5.rsp3.valid", 32'(bus.o_rsp_valid), 32'b1000);
        chk("t5.rsp3.data",  bus.o_rsp_data, 32'hC3);
        chk("t5.rsp3.ack",   32'(bus.o_arb_sleep_ack), 0);
        tick(); bus.i_rd_valid = 1'b0; set_req(0, 1'b1, 1'b1, 32'h60, 32'h66); settle();
        chk("t5.rsp1.valid", 32'(bus.o_rsp_valid), 32'b0010);
        chk("t5.rsp1.data",  bus.o_rsp_data, 32'hC1);
        chk("t5.rsp1.ack",   32'(bus.o_arb_sleep_ack), 0);
        tick(); settle();
        chk("t5.sleep.ack",   32'(bus.o_arb_sleep_ack), 1);
        chk("t5.sleep.valid", 32'(bus.o_valid), 0);
        tick(); bus.i_arb_sleep_req = 1'b0; settle();
        chk("t5.sleep2.ack",   32'(bus.o_arb_sleep_ack), 1);
        chk("t5.sleep2.valid", 32'(bus.o_valid), 0);
        tick(); settle();
        chk("t5.wake.ack",   32'(bus.o_arb_sleep_ack), 0);
        chk("t5.wake.valid", 32'(bus.o_valid), 0);
        tick(); settle();
        chk_grant("t5.resume", 0, 32'h60);
        tick(); bus.i_req_valid[0] = 1'b0; settle();
        chk("t5.resume_gap", 32'(bus.o_valid), 0);

        // 6: orphan response, then reset during a stalled grant with one read in flight
        bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'hEE;
        tick(); bus.i_rd_valid = 1'b0; settle();
        chk("t6.orphan",       32'(bus.o_rsp_orphan), 1);
        chk("t6.orphan.rsp",   32'(bus.o_rsp_valid), 0);
        chk("t6.orphan.data",  bus.o_rsp_data, 32'hC1);
        tick(); settle();
        chk("t6.orphan_end",   32'(bus.o_rsp_orphan), 0);
        set_req(2, 1'b1, 1'b0, 32'h80, 32'h0); settle();
        tick(); settle();
        chk_grant("t6.g2", 2, 32'h80);
        tick(); settle();
        chk("t6.gap", 32'(bus.o_valid), 0);
        tick(); bus.i_ready = 1'b0; settle();
        chk("t6.stall.valid", 32'(bus.o_valid), 1);
        rst = 1'b1; settle();
        chk("t6.rst.valid",     32'(bus.o_valid), 0);
        chk("t6.rst.req_ready", 32'(bus.o_req_ready), 0);
        chk("t6.rst.addr",      bus.o_addr, 0);
        chk("t6.rst.rsp_valid", 32'(bus.o_rsp_valid), 0);
        chk("t6.rst.rsp_data",  bus.o_rsp_data, 0);
        chk("t6.rst.ack",       32'(bus.o_arb_sleep_ack), 0);
        chk("t6.rst.orphan",    32'(bus.o_rsp_orphan), 0);
        tick(); rst = 1'b0; bus.i_req_valid = '0; bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'h99; settle();
        tick(); bus.i_rd_valid = 1'b0; settle();
        chk("t6.post_rst.orphan", 32'(bus.o_rsp_orphan), 1);
        chk("t6.post_rst.rsp",    32'(bus.o_rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
